addr4u_check_stage: RTL and testbench
=====================================

# addr4u_check_stage

Sequential result-checking stage placed directly downstream of the 4-bit unsigned fault-resilient adder. It takes each operand pair (A, B) and the adder's 5-bit output through a valid/ready handshake, recomputes the golden sum, and flags any mismatch. On a mismatch it can substitute the golden value, and it keeps error and transaction counters. After a programmable number of errors it halts intake, so the system can quarantine a faulty adder instance.

## Interface
- CNT_W, 8, width of err_cnt and tot_cnt (≥4)
- ERR_LIMIT, 4, err_cnt value that forces HALT; 0 = never halt
- CORRECT, 1, 1 = out_sum carries golden sum on mismatch; 0 = out_sum carries adder value unchanged
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous pulse: clears counters, leaves HALT
- in_valid  in  1  operand/result triple valid
- in_ready  out  1  stage accepts triple this cycle
- in_a  in  4  operand A[3:0] as fed to adder
- in_b  in  4  operand B[3:0] as fed to adder
- in_sum  in  5  adder output O[4:0]
- out_valid  out  1  checked result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  5  checked/corrected sum
- out_err  out  1  mismatch flag for the out_sum beat
- err_cnt  out  CNT_W  mismatches seen, saturating
- tot_cnt  out  CNT_W  triples checked, wrapping
- halted  out  1  1 in HALT state

## Operation
- Two register stages: S1 captures the triple; S2 holds out_sum/out_err.
- Golden = in_a + in_b, zero-extended to 5 bits. Mismatch = (S1 in_sum != golden).
- Transfers: input accepted when in_valid & in_ready. Output consumed when out_valid & out_ready.
- s2_free = !out_valid | out_ready.
- in_ready = !halted & (!s1_valid | s2_free). This is combinational from out_ready; there is no combinational path from in_valid.
- S1→S2 move when s1_valid & s2_free. On the move, tot_cnt increments; err_cnt increments on mismatch.
- err_cnt saturates at all-ones. tot_cnt wraps to 0.
- FSM states RUN and HALT; reset state is RUN.
- RUN→HALT on the cycle err_cnt's next value equals ERR_LIMIT (ERR_LIMIT≠0).
- HALT→RUN only on clr.
- In HALT, in_ready=0. Entries already in S1/S2 still drain and are still counted. err_cnt may exceed ERR_LIMIT while draining.
- clr takes priority over a same-cycle increment: counters end at 0, state RUN. clr does not flush S1/S2 contents or valid bits.
- Reset: all valids 0, out_sum 0, out_err 0, err_cnt 0, tot_cnt 0, halted 0, in_ready 1 after release.
- Reset asserted mid-operation drops in-flight entries immediately (asynchronous). No partial beats after release.
- out_sum/out_err are held stable while out_valid & !out_ready.

## Timing
- Latency: triple accepted at edge N → out_valid high after edge N+1 (two registers). The beat can be consumed at edge N+2.
- Throughput: one triple per cycle with out_ready held 1.
- Counters and halted update at the S1→S2 edge, i.e. visible in the same cycle as the corresponding out_valid.
- Backpressure: out_ready low for k cycles stalls at most 2 entries. in_ready drops the cycle after S1 and S2 are both full.
- halted rises the cycle after the limiting error moves to S2. in_ready is 0 in that same cycle.

## Test plan
- Reset, then in_a=15, in_b=15, in_sum=30, out_ready=1 → two cycles later out_sum=30, out_err=0, tot_cnt=1, err_cnt=0.
- in_a=9, in_b=7, in_sum=15 (fault), CORRECT=1 → out_sum=16, out_err=1, err_cnt=1. With CORRECT=0 → out_sum=15, out_err=1.
- Stream of 8 correct triples (one per cycle) with out_ready low for cycles 3–5 → no beat lost or duplicated, order preserved, in_ready low exactly while both stages are full, tot_cnt=8.
- ERR_LIMIT=4, four faulty triples back-to-back → halted=1 after the 4th, in_ready=0, a 5th in-flight faulty triple drains giving err_cnt=5; then clr → err_cnt=0, tot_cnt=0, halted=0, in_ready=1.
- clr asserted in the same cycle as a faulty S1→S2 move → err_cnt=0 and tot_cnt=0 next cycle; out_err=1 still presented for that beat.
- rst_n pulsed low while S1 and S2 are full → out_valid=0 immediately, all counters 0. After release, the first new triple appears after exactly 2 edges.

Source files
------------

// File: rtl/addr4u_check_stage.sv
// addr4u_check_stage
// Result-checking stage behind the 4-bit unsigned adder. Each (a, b, sum)
// triple is captured in S1. The golden sum is recomputed there, and the
// checked beat moves into S2. S2 drives the consumer.
// Error and transaction counters update when a beat moves from S1 to S2.
// When the error count reaches ERR_LIMIT, the stage stops accepting input
// until clr is asserted.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   clr                   sync pulse: zero counters, leave HALT
//   in_valid/in_ready     input handshake
//   in_a, in_b, in_sum    operands and adder output under test
//   out_valid/out_ready   output handshake
//   out_sum, out_err      checked (optionally corrected) sum, mismatch flag
//   err_cnt, tot_cnt      saturating error count, wrapping transaction count
//   halted                stage is in HALT
//
// state   | meaning
// ST_RUN  | normal operation, intake enabled
// ST_HALT | error limit reached, intake blocked, pipeline drains

module addr4u_check_stage #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_LIMIT = 4,
  parameter bit          CORRECT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [4:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_sum,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] tot_cnt,
  output logic             halted
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  // A limit the counter can never reach behaves like "never halt".
  localparam bit LIMIT_EN = (ERR_LIMIT != 0) &&
                            ((CNT_W >= 32) || (64'(ERR_LIMIT) < (64'd1 << CNT_W)));
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ERR_LIMIT);

  state_e           state_q, state_d;

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_a_q, s1_b_q;
  logic [4:0]       s1_sum_q;

  logic             s2_valid_q, s2_valid_d;
  logic [4:0]       s2_sum_q, s2_sum_d;
  logic             s2_err_q, s2_err_d;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] tot_cnt_q, tot_cnt_d;

  logic             s2_free, move, accept, halt_out;
  logic [4:0]       golden;
  logic             mismatch, err_inc, limit_hit;

  assign golden   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign mismatch = (s1_sum_q != golden);

  assign s2_free  = !s2_valid_q | out_ready;
  assign move     = s1_valid_q & s2_free;
  assign in_ready = !halt_out & (!s1_valid_q | s2_free);
  assign accept   = in_valid & in_ready;

  assign err_inc  = move & mismatch & (err_cnt_q != {CNT_W{1'b1}});

  always_comb begin
    err_cnt_d = err_cnt_q;
    tot_cnt_d = tot_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
      tot_cnt_d = '0;
    end else begin
      if (err_inc) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (move)    tot_cnt_d = tot_cnt_q + CNT_W'(1);
    end
  end

  // clr forces err_cnt_d to zero, and LIMIT is never zero when enabled.
  assign limit_hit = LIMIT_EN & err_inc & (err_cnt_d == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (!clr && limit_hit) state_d = ST_HALT;
      ST_HALT: if (clr)               state_d = ST_RUN;
      default:                        state_d = ST_RUN;
    endcase
  end

  always_comb begin
    halt_out = (state_q == ST_HALT);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)    s1_valid_d = 1'b1;
    else if (move) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_err_d   = s2_err_q;
    if (move) begin
      s2_valid_d = 1'b1;
      s2_sum_d   = (CORRECT && mismatch) ? golden : s1_sum_q;
      s2_err_d   = mismatch;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
      tot_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_sum_q <= in_sum;
      end
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
      tot_cnt_q  <= tot_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;
  assign tot_cnt   = tot_cnt_q;
  assign halted    = halt_out;

endmodule

// File: tb/tb_addr4u_check_stage.sv
module tb_addr4u_check_stage;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, out_ready;
  logic [3:0] in_a, in_b;
  logic [4:0] in_sum;

  logic       in_ready, out_valid, out_err, halted;
  logic [4:0] out_sum;
  logic [7:0] err_cnt, tot_cnt;

  logic       in_ready_nc, out_valid_nc, out_err_nc, halted_nc;
  logic [4:0] out_sum_nc;
  logic [7:0] err_cnt_nc, tot_cnt_nc;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: expected and observed beats, occupancy, counts since clr.
  logic [5:0] exp_q[$], exp_nc_q[$], obs_q[$], obs_nc_q[$];
  int occ = 0;
  int n_acc = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addr4u_check_stage #(.CNT_W(8), .ERR_LIMIT(4), .CORRECT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .err_cnt(err_cnt), .tot_cnt(tot_cnt), .halted(halted));

  addr4u_check_stage #(.CNT_W(8), .ERR_LIMIT(4), .CORRECT(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_nc),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .out_valid(out_valid_nc),
    .out_ready(out_ready), .out_sum(out_sum_nc), .out_err(out_err_nc),
    .err_cnt(err_cnt_nc), .tot_cnt(tot_cnt_nc), .halted(halted_nc));

  function automatic logic [5:0] ref_beat(input logic [3:0] a, input logic [3:0] b,
                                          input logic [4:0] s, input bit corr);
    int g;
    bit bad;
    g   = int'(a) + int'(b);
    bad = (int'(s) != g);
    return {(bad && corr) ? 5'(g) : s, bad};
  endfunction

  // One clock: record handshakes seen before the edge, then move to the next negedge.
  task automatic tick();
    bit acc, con;
    #1;
    acc = in_valid && in_ready;
    con = out_valid && out_ready;
    if (acc) begin
      exp_q.push_back(ref_beat(in_a, in_b, in_sum, 1'b1));
      exp_nc_q.push_back(ref_beat(in_a, in_b, in_sum, 1'b0));
      n_acc++;
      if (int'(in_sum) != int'(in_a) + int'(in_b)) n_err++;
    end
    if (con) begin
      obs_q.push_back({out_sum, out_err});
      obs_nc_q.push_back({out_sum_nc, out_err_nc});
    end
    occ = occ + int'(acc) - int'(con);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && occ != 0; i++) tick();
  endtask

  task automatic clear_model();
    exp_q.delete(); exp_nc_q.delete(); obs_q.delete(); obs_nc_q.delete();
    n_acc = 0;
    n_err = 0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_sum !== 5'd0) begin n_bad++; $display("FAIL reset_out_sum: got %0d want 0", out_sum); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %0b want 0", out_err); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (tot_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_tot_cnt: got %0d want 0", tot_cnt); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %0b want 0", halted); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15; in_sum = 5'd30;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_sum !== 5'd30) begin n_bad++; $display("FAIL basic_sum: got %0d want 30", out_sum); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %0b want 0", out_err); end
    n_cmp++; if (tot_cnt !== 8'd1) begin n_bad++; $display("FAIL basic_tot: got %0d want 1", tot_cnt); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL basic_errcnt: got %0d want 0", err_cnt); end
    drain();
  endtask

  task automatic test_fault();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd7; in_sum = 5'd15;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_sum !== 5'd16) begin n_bad++; $display("FAIL fault_corr_sum: got %0d want 16", out_sum); end
    n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL fault_corr_err: got %0b want 1", out_err); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL fault_errcnt: got %0d want 1", err_cnt); end
    n_cmp++; if (out_sum_nc !== 5'd15) begin n_bad++; $display("FAIL fault_nc_sum: got %0d want 15", out_sum_nc); end
    n_cmp++; if (out_err_nc !== 1'b1) begin n_bad++; $display("FAIL fault_nc_err: got %0b want 1", out_err_nc); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [3:0] a_t[8], b_t[8];
    int idx;
    bit exp_rdy;
    pulse_clr();
    for (int i = 0; i < 8; i++) begin
      a_t[i] = 4'($urandom_range(0, 15));
      b_t[i] = 4'($urandom_range(0, 15));
    end
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 8 || occ != 0); cyc++) begin
      in_valid  = (idx < 8);
      in_a      = a_t[idx % 8];
      in_b      = b_t[idx % 8];
      in_sum    = 5'(int'(a_t[idx % 8]) + int'(b_t[idx % 8]));
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      exp_rdy = !(occ == 2 && !out_ready);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_bad++; $display("FAIL bp_in_ready cyc %0d: got %0b want %0b", cyc, in_ready, exp_rdy);
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (idx != 8 || occ != 0) begin n_bad++; $display("FAIL bp_timeout: accepted %0d occ %0d want 8 and 0", idx, occ); end
    n_cmp++; if (obs_q.size() != 8) begin n_bad++; $display("FAIL bp_count: got %0d beats want 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (tot_cnt !== 8'd8) begin n_bad++; $display("FAIL bp_tot: got %0d want 8", tot_cnt); end
  endtask

  task automatic test_random();
    int sent, faults;
    bit exp_rdy;
    pulse_clr();
    sent = 0;
    faults = 0;
    for (int cyc = 0; cyc < 400 && sent < 60; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 4'($urandom_range(0, 15));
      in_b      = 4'($urandom_range(0, 15));
      in_sum    = 5'(int'(in_a) + int'(in_b));
      if (faults < 3 && $urandom_range(0, 7) == 0) begin
        in_sum = in_sum ^ 5'(1 << $urandom_range(0, 4));
        faults++;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_rdy = !(occ == 2 && !out_ready);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_bad++; $display("FAIL rnd_in_ready cyc %0d: got %0b want %0b", cyc, in_ready, exp_rdy);
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    drain();
    n_cmp++; if (occ != 0) begin n_bad++; $display("FAIL rnd_drain_timeout: occ %0d want 0", occ); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_nc_q[i] !== exp_nc_q[i]) begin
        n_bad++; $display("FAIL rnd_beat %0d: got %h/%h want %h/%h", i, obs_q[i], obs_nc_q[i], exp_q[i], exp_nc_q[i]);
      end
    end
    n_cmp++; if (int'(tot_cnt) != n_acc) begin n_bad++; $display("FAIL rnd_tot: got %0d want %0d", tot_cnt, n_acc); end
    n_cmp++; if (int'(err_cnt) != n_err) begin n_bad++; $display("FAIL rnd_errcnt: got %0d want %0d", err_cnt, n_err); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rnd_halted: got %0b want 0", halted); end
  endtask

  task automatic test_halt();
    pulse_clr();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = 4'(i + 1); in_b = 4'd3; in_sum = 5'(i + 20);
      if (i == 4) begin
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_early: got %0b want 0", halted); end
      end
      tick();
    end
    #1;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_rise: got %0b want 1", halted); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL halt_in_ready: got %0b want 0", in_ready); end
    n_cmp++; if (err_cnt !== 8'd4) begin n_bad++; $display("FAIL halt_errcnt4: got %0d want 4", err_cnt); end
    in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1; in_sum = 5'd9;
    tick();
    tick();
    drain();
    n_cmp++; if (n_acc != 5) begin n_bad++; $display("FAIL halt_accepted: got %0d want 5", n_acc); end
    n_cmp++; if (err_cnt !== 8'd5) begin n_bad++; $display("FAIL halt_errcnt5: got %0d want 5", err_cnt); end
    n_cmp++; if (tot_cnt !== 8'd5) begin n_bad++; $display("FAIL halt_tot: got %0d want 5", tot_cnt); end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold: got %0b want 1", halted); end
    n_cmp++; if (obs_q.size() != 5) begin n_bad++; $display("FAIL halt_beats: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL halt_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    pulse_clr();
    #1;
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL halt_clr_err: got %0d want 0", err_cnt); end
    n_cmp++; if (tot_cnt !== 8'd0) begin n_bad++; $display("FAIL halt_clr_tot: got %0d want 0", tot_cnt); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_clr_halted: got %0b want 0", halted); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL halt_clr_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_clr_same_cycle();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd6; in_b = 4'd5; in_sum = 5'd2;
    tick();
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL sc_errcnt: got %0d want 0", err_cnt); end
    n_cmp++; if (tot_cnt !== 8'd0) begin n_bad++; $display("FAIL sc_tot: got %0d want 0", tot_cnt); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sc_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL sc_err: got %0b want 1", out_err); end
    n_cmp++; if (out_sum !== 5'd11) begin n_bad++; $display("FAIL sc_sum: got %0d want 11", out_sum); end
    drain();
    clear_model();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'd2; in_b = 4'd2; in_sum = 5'd4;
    tick();
    in_a = 4'd3; in_b = 4'd3; in_sum = 5'd6;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || tot_cnt !== 8'd1) begin
      n_bad++; $display("FAIL rm_pre: got valid %0b tot %0d want 1 and 1", out_valid, tot_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %0b want 0", out_valid); end
    n_cmp++; if (tot_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL rm_counters: got tot %0d err %0d want 0 and 0", tot_cnt, err_cnt);
    end
    clear_model();
    occ = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4; in_sum = 5'd7;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_one_edge: got %0b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 5'd7) begin
      n_bad++; $display("FAIL rm_two_edge: got valid %0b sum %0d want 1 and 7", out_valid, out_sum);
    end
    drain();
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL rm_beats: got %0d want 1", obs_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sum = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_fault();
    test_backpressure();
    test_random();
    test_halt();
    test_clr_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
